// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer:
// reconfig register map, sequencer states and the table entry payload.
package pll_cfg_pkg;

  // PLL reconfig core register addresses
  localparam logic [5:0] ADDR_MODE   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_START  = 6'h02;
  localparam logic [5:0] ADDR_N      = 6'h03;
  localparam logic [5:0] ADDR_M      = 6'h04;
  localparam logic [5:0] ADDR_C      = 6'h05;
  localparam logic [5:0] ADDR_K      = 6'h07;

  // Timeout counter width (saturating)
  localparam int unsigned TMO_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_PARAM,
    ST_START,
    ST_POLL,
    ST_LOCK,
    ST_FIN
  } state_t;

  // One parameter-table entry: reconfig register address and its data
  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } tbl_entry_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk, rst (sync active-high, clears both flops), d (async in), q (synchronized out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: programs a PLL reconfig core over Avalon-MM
// from a small parameter table, starts the reconfig, polls status, then waits
// for PLL lock, with a saturating timeout on both waits.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   tbl_we/tbl_idx/tbl_addr/tbl_data  parameter table write port (ignored while busy)
//   start, cnt                    launch a sequence applying cnt entries (clamped)
//   busy, done, err               status: in progress, end pulse, sticky timeout
//   mgmt_*                        Avalon-MM master to the reconfig core
//   pll_locked                    asynchronous PLL lock indication
module pll_cfg_seq #(
  parameter  int unsigned NUM_ENTRIES = 8,
  parameter  int unsigned TIMEOUT_CYC = 65535,
  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_idx,
  input  logic [5:0]       tbl_addr,
  input  logic [31:0]      tbl_data,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [5:0]       mgmt_address,
  output logic             mgmt_read,
  output logic             mgmt_write,
  output logic [31:0]      mgmt_writedata,
  input  logic [31:0]      mgmt_readdata,
  input  logic             mgmt_waitrequest,
  input  logic             pll_locked
);

  import pll_cfg_pkg::*;

  // Last counted cycle of a POLL/LOCK wait before giving up
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [TMO_W-1:0] tmo, tmo_n;
  logic             busy_n, done_n, err_n;
  logic             rd_n, wr_n;
  logic [5:0]       addr_n;
  logic [31:0]      wdata_n;
  logic             lock_s;
  logic             xfer_c;
  logic             unused_rd;

  tbl_entry_t tbl [NUM_ENTRIES];

  // Only the status busy/done bit of the read word matters
  assign unused_rd = ^mgmt_readdata[31:1];

  // A pending command completes in any cycle without a stall
  assign xfer_c = !mgmt_waitrequest;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Parameter table, retained across reset
  always_ff @(posedge clk) begin
    if (tbl_we && !busy) begin
      tbl[tbl_idx] <= '{addr: tbl_addr, data: tbl_data};
    end
  end

  // Next state, then bus command and status decoded from the next state
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt_q;
    err_n   = err;
    tmo_n   = (tmo == '1) ? tmo : tmo + TMO_W'(1);

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_MODE;
          err_n   = 1'b0;
          cnt_n   = (cnt > CNT_W'(NUM_ENTRIES)) ? CNT_W'(NUM_ENTRIES) : cnt;
        end
      end
      ST_MODE: begin
        if (xfer_c) begin
          idx_n   = '0;
          state_n = (cnt_q == '0) ? ST_START : ST_PARAM;
        end
      end
      ST_PARAM: begin
        if (xfer_c) begin
          if (CNT_W'(idx) + CNT_W'(1) == cnt_q) begin
            state_n = ST_START;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      ST_START: begin
        if (xfer_c) begin
          state_n = ST_POLL;
          tmo_n   = '0;
        end
      end
      ST_POLL: begin
        if (xfer_c && mgmt_readdata[0]) begin
          state_n = ST_LOCK;
          tmo_n   = '0;
        end else if (tmo >= TMO_LAST) begin
          state_n = ST_FIN;
          err_n   = 1'b1;
        end
      end
      ST_LOCK: begin
        if (lock_s) begin
          state_n = ST_FIN;
        end else if (tmo >= TMO_LAST) begin
          state_n = ST_FIN;
          err_n   = 1'b1;
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    busy_n  = (state_n != ST_IDLE) && (state_n != ST_FIN);
    done_n  = (state_n == ST_FIN);
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    addr_n  = '0;
    wdata_n = '0;

    // Command follows state/index, so it holds unchanged across a stall
    case (state_n)
      ST_MODE: begin
        wr_n    = 1'b1;
        addr_n  = ADDR_MODE;
        wdata_n = 32'h1;
      end
      ST_PARAM: begin
        wr_n    = 1'b1;
        addr_n  = tbl[idx_n].addr;
        wdata_n = tbl[idx_n].data;
      end
      ST_START: begin
        wr_n    = 1'b1;
        addr_n  = ADDR_START;
        wdata_n = 32'h0;
      end
      ST_POLL: begin
        rd_n    = 1'b1;
        addr_n  = ADDR_STATUS;
      end
      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      idx            <= '0;
      cnt_q          <= '0;
      tmo            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      mgmt_read      <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      cnt_q          <= cnt_n;
      tmo            <= tmo_n;
      busy           <= busy_n;
      done           <= done_n;
      err            <= err_n;
      mgmt_read      <= rd_n;
      mgmt_write     <= wr_n;
      mgmt_address   <= addr_n;
      mgmt_writedata <= wdata_n;
    end
  end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Self-checking bench for pll_cfg_seq: a bus monitor checks protocol rules every
// cycle and logs completed transfers; each sequence is compared with the transfer
// list and timing expected from the table contents and the stimulus choices.
module tb_pll_cfg_seq;

  localparam int unsigned N = 8;
  localparam int unsigned T = 16;

  typedef struct packed { logic wr; logic [5:0] a; logic [31:0] d; } xact_t;
  typedef struct packed { logic [5:0] a; logic [31:0] d; } tent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tbl_we = 1'b0;
  logic [2:0]  tbl_idx = '0;
  logic [5:0]  tbl_addr = '0;
  logic [31:0] tbl_data = '0;
  logic        start = 1'b0;
  logic [3:0]  cnt = '0;
  logic        busy, done, err, mgmt_read, mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata = '0;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b0;

  pll_cfg_seq #(.NUM_ENTRIES(N), .TIMEOUT_CYC(T)) dut (
    .clk              (clk),
    .rst              (rst),
    .tbl_we           (tbl_we),
    .tbl_idx          (tbl_idx),
    .tbl_addr         (tbl_addr),
    .tbl_data         (tbl_data),
    .start            (start),
    .cnt              (cnt),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .mgmt_address     (mgmt_address),
    .mgmt_read        (mgmt_read),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor state
  xact_t       got_q[$];
  int          wr_done = 0, rd_done = 0, done_cnt = 0, done_cyc = -1;
  int          status_cyc = -1, status_cnt = 0;
  logic        done_err = 1'b0;
  logic        prev_stall = 1'b0;
  logic [39:0] prev_cmd = '0;

  // Per-cycle protocol checks and transfer logging
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_wr_exclusive", 64'(mgmt_read & mgmt_write), 64'd0);
      if (done) chk("busy_low_on_done", 64'(busy), 64'd0);
      if (!busy) chk("idle_bus_quiet", 64'({mgmt_read, mgmt_write}), 64'd0);
      if (prev_stall)
        chk("stall_hold", 64'({mgmt_read, mgmt_write, mgmt_address, mgmt_writedata}), 64'(prev_cmd));
      if ((mgmt_read || mgmt_write) && !mgmt_waitrequest) begin
        got_q.push_back({mgmt_write, mgmt_address, mgmt_write ? mgmt_writedata : 32'h0});
        if (mgmt_write) wr_done++;
        else begin
          rd_done++;
          if (mgmt_readdata[0]) begin
            status_cnt++;
            status_cyc = cyc;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = err;
      end
    end
    prev_stall = !rst && (mgmt_read || mgmt_write) && mgmt_waitrequest;
    prev_cmd   = {mgmt_read, mgmt_write, mgmt_address, mgmt_writedata};
  end

  // Slave model: stalls per mode, status bit set on the st_at-th read
  int st_at = 0, stall_mode = 0, rd_base = 0, wr_base = 0, stall_tot = 0, stall_base = 0;

  always @(posedge clk) begin
    #1;
    if (mgmt_write && stall_mode == 1)
      mgmt_waitrequest = ($urandom_range(0, 3) == 0);
    else if (mgmt_write && stall_mode == 2 && wr_done - wr_base == 1 && stall_tot - stall_base < 7) begin
      mgmt_waitrequest = 1'b1;
      stall_tot++;
    end else
      mgmt_waitrequest = 1'b0;
    mgmt_readdata = {31'($urandom()), (st_at != 0) && (rd_done - rd_base + 1 >= st_at)};
  end

  tent_t tbl_m [N];
  xact_t exp_q[$];
  int    base = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_tbl(input int i, input logic [5:0] a, input logic [31:0] d);
    tbl_we = 1'b1; tbl_idx = 3'(i); tbl_addr = a; tbl_data = d;
    tick();
    tbl_we = 1'b0;
    tbl_m[i] = {a, d};
  endtask

  // One sequence: c entries, status on read sa (0 = never), lock ld cycles
  // after the status read (-1 = never), stall mode sm, poke = illegal pulses.
  task automatic run_seq(input string nm, input int c, input int sa, input int ld,
                         input int sm, input bit poke);
    int d0, s0, lock_cyc, nrd, cmin;
    bit lock_set, pk_we, pk_st, exp_err;
    base = got_q.size(); rd_base = rd_done; wr_base = wr_done; stall_base = stall_tot;
    d0 = done_cnt; s0 = status_cnt; st_at = sa; stall_mode = sm;
    lock_set = 0; pk_we = 0; pk_st = 0; lock_cyc = -1;
    pll_locked = 1'b0;
    repeat (3) tick();
    start = 1'b1; cnt = 4'(c);
    tick();
    start = 1'b0;
    chk({nm, ":busy_after_start"}, 64'(busy), 64'd1);
    chk({nm, ":err_cleared"}, 64'(err), 64'd0);
    for (int k = 0; k < 400 && done_cnt == d0; k++) begin
      if (poke && !pk_we && wr_done - wr_base == 2) begin
        tbl_we = 1'b1; tbl_idx = 3'd0; tbl_addr = 6'h3f; tbl_data = 32'hdead_beef; pk_we = 1;
      end
      if (poke && !pk_st && rd_done - rd_base == 1) begin
        start = 1'b1; cnt = 4'd1; pk_st = 1;
      end
      if (ld >= 0 && !lock_set && status_cnt != s0 && cyc >= status_cyc + 1 + ld) begin
        pll_locked = 1'b1; lock_cyc = cyc; lock_set = 1;
      end
      tick();
      tbl_we = 1'b0; start = 1'b0;
    end
    repeat (4) tick();
    chk({nm, ":one_done_pulse"}, 64'(done_cnt - d0), 64'd1);
    exp_err = (sa == 0) || (ld < 0);
    chk({nm, ":err_at_done"}, 64'(done_err), 64'(exp_err));
    chk({nm, ":err_sticky"}, 64'(err), 64'(exp_err));
    if (!exp_err) chk({nm, ":lock_to_done"}, 64'(done_cyc), 64'(lock_cyc + 3));
    else if (sa != 0) chk({nm, ":lock_timeout_at"}, 64'(done_cyc), 64'(status_cyc + 1 + T));
    if (sm == 2) chk({nm, ":stall_len"}, 64'(stall_tot - stall_base), 64'd7);
    // Expected bus transfers from table and stimulus
    cmin = (c > int'(N)) ? int'(N) : c;
    nrd  = (sa == 0) ? int'(T) : sa;
    exp_q.delete();
    exp_q.push_back({1'b1, 6'h00, 32'h1});
    for (int i = 0; i < cmin; i++) exp_q.push_back({1'b1, tbl_m[i].a, tbl_m[i].d});
    exp_q.push_back({1'b1, 6'h02, 32'h0});
    for (int i = 0; i < nrd; i++) exp_q.push_back({1'b0, 6'h01, 32'h0});
    chk({nm, ":n_xact"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
      chk({nm, ":xact"}, 64'(got_q[base + i]), 64'(exp_q[i]));
  endtask

  initial begin
    xact_t lit [7];
    int    nw, k0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:busy", 64'(busy), 64'd0);
    chk("rst:done", 64'(done), 64'd0);
    chk("rst:err", 64'(err), 64'd0);
    chk("rst:read", 64'(mgmt_read), 64'd0);
    chk("rst:write", 64'(mgmt_write), 64'd0);
    chk("rst:addr", 64'(mgmt_address), 64'd0);
    chk("rst:wdata", 64'(mgmt_writedata), 64'd0);
    rst = 1'b0;
    tick();

    wr_tbl(0, 6'h04, 32'h0000_0404);
    wr_tbl(1, 6'h03, 32'h0001_0000);
    wr_tbl(2, 6'h07, 32'h9746_3C67);
    for (int i = 3; i < int'(N); i++) wr_tbl(i, 6'(i + 8), $urandom());

    // Reference sequence, pinned against hand-written transfers
    run_seq("basic", 3, 2, 5, 0, 0);
    lit[0] = {1'b1, 6'h00, 32'h1};
    lit[1] = {1'b1, 6'h04, 32'h0000_0404};
    lit[2] = {1'b1, 6'h03, 32'h0001_0000};
    lit[3] = {1'b1, 6'h07, 32'h9746_3C67};
    lit[4] = {1'b1, 6'h02, 32'h0};
    lit[5] = {1'b0, 6'h01, 32'h0};
    lit[6] = {1'b0, 6'h01, 32'h0};
    for (int i = 0; i < 7 && base + i < got_q.size(); i++)
      chk("basic:literal", 64'(got_q[base + i]), 64'(lit[i]));

    run_seq("stall7", 3, 2, 5, 2, 0);
    for (int i = 0; i < 7 && base + i < got_q.size(); i++)
      chk("stall7:literal", 64'(got_q[base + i]), 64'(lit[i]));

    run_seq("poll_tmo", 1, 0, -1, 0, 0);
    chk("poll_tmo:literal_n", 64'(got_q.size() - base), 64'd19);

    run_seq("lock_tmo", 2, 3, -1, 0, 0);

    run_seq("cnt0", 0, 1, 2, 0, 0);
    if (base + 1 < got_q.size()) chk("cnt0:second_is_start", 64'(got_q[base + 1].a), 64'h02);

    run_seq("cnt12", 12, 1, 3, 1, 0);
    nw = 0;
    for (int i = base; i < got_q.size(); i++) if (got_q[i].wr) nw++;
    chk("cnt12:literal_writes", 64'(nw), 64'd10);

    // Reset in the middle of PARAM
    stall_mode = 0; pll_locked = 1'b0;
    k0 = wr_done;
    start = 1'b1; cnt = 4'd8;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50 && wr_done - k0 < 3; k++) tick();
    chk("rst_mid:write_active", 64'(mgmt_write), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid:write_dropped", 64'(mgmt_write), 64'd0);
    chk("rst_mid:busy_dropped", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();
    run_seq("replay", 8, 2, 4, 0, 0);

    // Illegal start in POLL and table write in PARAM
    run_seq("poke", 8, 3, 2, 0, 1);
    run_seq("post_poke", 1, 1, 1, 0, 0);
    if (base + 1 < got_q.size())
      chk("post_poke:entry0_kept", 64'(got_q[base + 1]), 64'({1'b1, 6'h04, 32'h0000_0404}));

    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 3; j++) wr_tbl(int'($urandom_range(0, N - 1)), 6'($urandom()), $urandom());
      run_seq("rand", int'($urandom_range(0, 15)), int'($urandom_range(1, 4)),
              int'($urandom_range(0, 8)), int'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
